vector_fetch: RTL and testbench
===============================

Name: vector_fetch

Overview:
Upstream sequencer for the 8-bit memory block: on request, reads a 16-bit little-endian 6502 vector (RESET/NMI/IRQ-BRK) as two byte reads.
- Drives memory enable/address, captures rd_data, returns the assembled vector with a one-cycle done pulse.
- Sits between CPU control logic and the memory; used at reset and on interrupt entry to load PC.

Parameters:
ADDR_WIDTH, 16, memory address width
DATA_WIDTH, 8, memory data width; vector width is 2*DATA_WIDTH
RD_LATENCY, 1, cycles from the enable cycle to valid mem_rd_data; 0 = combinational read, legal range 0-7
RESET_VECTOR, 16'hFFFC, low-byte address of the RESET vector
NMI_VECTOR, 16'hFFFA, low-byte address of the NMI vector
IRQ_VECTOR, 16'hFFFE, low-byte address of the IRQ/BRK vector

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req  in  1  fetch request; sampled only when busy=0
vec_sel  in  2  00=RESET, 01=NMI, 10=IRQ, 11=reserved; sampled with req
busy  out  1  fetch in progress
done  out  1  one-cycle pulse; vector valid this cycle
vector  out  2*DATA_WIDTH  {high byte, low byte}; held until the next done
err  out  1  one-cycle pulse on reserved vec_sel (see Optional Feature)
mem_enable  out  1  memory access strobe
mem_address  out  ADDR_WIDTH  memory address
mem_rd_data  in  DATA_WIDTH  memory read data

Behaviour:
- Reset (synchronous, active-high) forces: state IDLE, busy=0, done=0, err=0, mem_enable=0, mem_address=0, vector=0. All outputs are registered.
- FSM states: IDLE, RD_LO, WAIT_LO, RD_HI, WAIT_HI, DONE.
  - WAIT states are skipped when RD_LATENCY=0.
  - Wait counter width is 3 bits.
- Accept: req=1 with state IDLE in cycle n latches base = the address selected by vec_sel.
- Timing, with L=RD_LATENCY:
  - n+1: RD_LO; mem_enable=1, mem_address=base, busy=1.
  - n+1+L: mem_rd_data captured as low byte. mem_enable=1 for exactly one cycle per byte and is 0 in WAIT states. mem_address holds its value until the next RD state.
  - n+2+L: RD_HI; mem_enable=1, mem_address=base+1.
  - n+2+2L: high byte captured.
  - n+3+2L: DONE; done=1, vector updated, busy=1.
  - n+4+2L: IDLE, busy=0.
- req while busy=1, including the DONE cycle, is ignored; it is not queued.
- base+1 is computed modulo 2^ADDR_WIDTH, so FFFF wraps to 0000.
- vec_sel=11 without the macro aliases to IRQ_VECTOR (BRK shares the IRQ vector).
- Reset mid-fetch:
  - Next cycle: IDLE, mem_enable=0, no done pulse, vector=0.
  - Partial low byte is discarded.
- mem_rd_data is ignored outside capture cycles.
- No write path; the block never writes memory.

Optional Feature:
Macro VECTOR_FETCH_RSVD_ERR_EN.
- Defined: vec_sel=11 with req in IDLE produces no memory access and busy stays 0. err=1 for exactly cycle n+1; vector is unchanged and done stays 0.
- Undefined: err is tied 0 and vec_sel=11 fetches IRQ_VECTOR.

Test Plan:
1. Default build, memory[FFFC]=00, [FFFD]=80; req with vec_sel=00 at cycle n -> the bench checks:
   - enable/address FFFC at n+1 and FFFD at n+3.
   - done=1 and vector=16'h8000 at n+5; busy=0 at n+6.
2. RD_LATENCY=0, memory[FFFA]=34, [FFFB]=12; NMI request -> vector=16'h1234 with done at n+3; enable high at n+1 and n+2 only.
3. IRQ fetch in progress; req pulsed with vec_sel=00 at n+2 and at the DONE cycle -> both ignored; exactly one done; address never equals FFFC.
4. reset=1 at n+3 mid-fetch (default build) -> at n+4 state IDLE, mem_enable=0, vector=0, no done; a new RESET request then completes normally.
5. RESET_VECTOR=16'hFFFF, memory[FFFF]=CD, [0000]=AB -> addresses FFFF then 0000; vector=16'hABCD.
6. vec_sel=11, memory[FFFE]=EF, [FFFF]=BE:
   - Without macro -> vector=16'hBEEF.
   - With VECTOR_FETCH_RSVD_ERR_EN -> err pulse at n+1, no mem_enable, done=0, vector unchanged.

Source files
------------

// File: rtl/vector_fetch_if.sv
// Byte-wide read-only memory port between the vector fetcher and the memory block.
interface vector_fetch_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  mem_enable;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  modport master (output mem_enable, output mem_address, input mem_rd_data);
  modport slave  (input mem_enable, input mem_address, output mem_rd_data);
endinterface

// File: rtl/vector_fetch.sv
// 6502 vector fetcher: reads a 16-bit little-endian vector as two byte reads.
// Optional macro VECTOR_FETCH_RSVD_ERR_EN: vec_sel=11 raises err instead of fetching IRQ.
module vector_fetch #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    RD_LATENCY   = 1,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 'hFFFC,
  parameter logic [ADDR_WIDTH-1:0] NMI_VECTOR   = 'hFFFA,
  parameter logic [ADDR_WIDTH-1:0] IRQ_VECTOR   = 'hFFFE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req,
  input  logic [1:0]              vec_sel,
  output logic                    busy,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] vector,
  output logic                    err,
  vector_fetch_if.master          mem
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_LO   = 3'd1;
  localparam logic [2:0] S_WAIT_LO = 3'd2;
  localparam logic [2:0] S_RD_HI   = 3'd3;
  localparam logic [2:0] S_WAIT_HI = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam bit         NO_WAIT   = (RD_LATENCY == 0);
  localparam logic [2:0] WAIT_LAST = NO_WAIT ? 3'd0 : 3'(RD_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]            state, state_nxt, wait_cnt;
  logic [ADDR_WIDTH-1:0] base, sel_addr;
  logic [DATA_WIDTH-1:0] lo_byte;
  logic                  rsvd, start, cap_lo, cap_hi;

  always_comb begin
    case (vec_sel)
      2'b00:   sel_addr = RESET_VECTOR;
      2'b01:   sel_addr = NMI_VECTOR;
      default: sel_addr = IRQ_VECTOR;  // BRK shares the IRQ vector
    endcase
  end

`ifdef VECTOR_FETCH_RSVD_ERR_EN
  assign rsvd = (vec_sel == 2'b11);
`else
  assign rsvd = 1'b0;
`endif

  assign start  = (state == S_IDLE) && req && !rsvd;
  // With zero latency the byte is captured in the RD cycle itself.
  assign cap_lo = ((state == S_RD_LO) && NO_WAIT) ||
                  ((state == S_WAIT_LO) && (wait_cnt == WAIT_LAST));
  assign cap_hi = ((state == S_RD_HI) && NO_WAIT) ||
                  ((state == S_WAIT_HI) && (wait_cnt == WAIT_LAST));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_RD_LO;
      S_RD_LO:   state_nxt = NO_WAIT ? S_RD_HI : S_WAIT_LO;
      S_WAIT_LO: if (cap_lo) state_nxt = S_RD_HI;
      S_RD_HI:   state_nxt = NO_WAIT ? S_DONE : S_WAIT_HI;
      S_WAIT_HI: if (cap_hi) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      wait_cnt        <= 3'd0;
      base            <= '0;
      lo_byte         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      vector          <= '0;
      mem.mem_enable  <= 1'b0;
      mem.mem_address <= '0;
    end else begin
      state          <= state_nxt;
      busy           <= (state_nxt != S_IDLE);
      done           <= (state_nxt == S_DONE);
      mem.mem_enable <= (state_nxt == S_RD_LO) || (state_nxt == S_RD_HI);

      if (((state == S_WAIT_LO) && !cap_lo) || ((state == S_WAIT_HI) && !cap_hi))
        wait_cnt <= wait_cnt + 3'd1;
      else
        wait_cnt <= 3'd0;

      if (start) begin
        base            <= sel_addr;
        mem.mem_address <= sel_addr;
      end
      // Address wraps modulo 2^ADDR_WIDTH for the high byte.
      if (cap_lo) begin
        lo_byte         <= mem.mem_rd_data;
        mem.mem_address <= base + ADDR_ONE;
      end
      if (cap_hi)
        vector <= {mem.mem_rd_data, lo_byte};

`ifdef VECTOR_FETCH_RSVD_ERR_EN
      err <= (state == S_IDLE) && req && rsvd;
`else
      err <= 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_vector_fetch.sv
// Self-checking bench for vector_fetch: three instances (latency 1, 0, 3) against a cycle model.
module tb_vector_fetch;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

`ifdef VECTOR_FETCH_RSVD_ERR_EN
  localparam bit RSVD = 1'b1;
`else
  localparam bit RSVD = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] last_vec [3];
  logic [7:0]  junk;
  always @(negedge clk) junk <= 8'($urandom);

  logic        req_a = 0, req_b = 0, req_c = 0;
  logic [1:0]  sel_a = 0, sel_b = 0, sel_c = 0;
  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c, err_a, err_b, err_c;
  logic [15:0] vec_a, vec_b, vec_c;

  vector_fetch_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) ifa ();
  vector_fetch_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) ifb ();
  vector_fetch_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) ifc ();

  vector_fetch #(.RD_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .vec_sel(sel_a), .busy(busy_a),
    .done(done_a), .vector(vec_a), .err(err_a), .mem(ifa));
  vector_fetch #(.RD_LATENCY(0)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .vec_sel(sel_b), .busy(busy_b),
    .done(done_b), .vector(vec_b), .err(err_b), .mem(ifb));
  vector_fetch #(.RD_LATENCY(3), .RESET_VECTOR(16'hFFFF)) dut_c (
    .clk(clk), .reset(reset), .req(req_c), .vec_sel(sel_c), .busy(busy_c),
    .done(done_c), .vector(vec_c), .err(err_c), .mem(ifc));

  // Memory models: data valid only in the capture cycle, random junk otherwise.
  logic [8:0] pa;
  logic [8:0] pc [3];
  always @(posedge clk) begin
    pa    <= {ifa.mem_enable, mem[ifa.mem_address]};
    pc[0] <= {ifc.mem_enable, mem[ifc.mem_address]};
    pc[1] <= pc[0];
    pc[2] <= pc[1];
  end
  assign ifa.mem_rd_data = pa[8] ? pa[7:0] : junk;
  assign ifb.mem_rd_data = ifb.mem_enable ? mem[ifb.mem_address] : junk;
  assign ifc.mem_rd_data = pc[2][8] ? pc[2][7:0] : junk;

  function automatic int lat(input int u);
    return (u == 0) ? 1 : (u == 1) ? 0 : 3;
  endfunction

  function automatic logic [15:0] vaddr(input int u, input logic [1:0] s);
    case (s)
      2'd0:    return (u == 2) ? 16'hFFFF : 16'hFFFC;
      2'd1:    return 16'hFFFA;
      default: return 16'hFFFE;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int u, input logic r, input logic [1:0] s);
    case (u)
      0: begin req_a = r; sel_a = s; end
      1: begin req_b = r; sel_b = s; end
      default: begin req_c = r; sel_c = s; end
    endcase
  endtask

  task automatic sample(input int u, output logic en, output logic [15:0] ad,
                        output logic bz, output logic dn, output logic er,
                        output logic [15:0] vc);
    case (u)
      0: begin en = ifa.mem_enable; ad = ifa.mem_address; bz = busy_a; dn = done_a; er = err_a; vc = vec_a; end
      1: begin en = ifb.mem_enable; ad = ifb.mem_address; bz = busy_b; dn = done_b; er = err_b; vc = vec_b; end
      default: begin en = ifc.mem_enable; ad = ifc.mem_address; bz = busy_c; dn = done_c; er = err_c; vc = vec_c; end
    endcase
  endtask

  // One request at cycle n; poke[k] drives an extra RESET request during cycle n+k.
  task automatic run_fetch(input int u, input logic [1:0] s, input logic [15:0] poke,
                           output int ndone, output bit saw_fffc);
    int L, last;
    bit rsvd;
    logic [15:0] base, base1, expv;
    logic en, bz, dn, er;
    logic [15:0] ad, vc;
    L     = lat(u);
    rsvd  = RSVD && (s == 2'b11);
    base  = vaddr(u, s);
    base1 = base + 16'd1;
    expv  = {mem[base1], mem[base]};
    last  = rsvd ? 1 : 4 + 2 * L;
    ndone = 0;
    saw_fffc = 0;
    drive(u, 1'b1, s);
    tick();
    for (int k = 1; k <= last + 2; k++) begin
      drive(u, (k < last) ? poke[k] : 1'b0, 2'b00);
      sample(u, en, ad, bz, dn, er, vc);
      if (dn) ndone++;
      if (en && ad == 16'hFFFC) saw_fffc = 1;
      checks += 5;
      if (en !== (!rsvd && (k == 1 || k == 2 + L))) begin
        errors++; $display("FAIL enable u%0d k%0d got %b", u, k, en);
      end
      if (bz !== (!rsvd && k < last)) begin
        errors++; $display("FAIL busy u%0d k%0d got %b", u, k, bz);
      end
      if (dn !== (!rsvd && k == 3 + 2 * L)) begin
        errors++; $display("FAIL done u%0d k%0d got %b", u, k, dn);
      end
      if (er !== (rsvd && k == 1)) begin
        errors++; $display("FAIL err u%0d k%0d got %b", u, k, er);
      end
      if (vc !== ((!rsvd && k >= 3 + 2 * L) ? expv : last_vec[u])) begin
        errors++; $display("FAIL vector u%0d k%0d got %h exp %h", u, k, vc,
                           (!rsvd && k >= 3 + 2 * L) ? expv : last_vec[u]);
      end
      if (!rsvd && (k == 1 || k == 2 + L)) begin
        checks++;
        if (ad !== ((k == 1) ? base : base1)) begin
          errors++; $display("FAIL address u%0d k%0d got %h exp %h", u, k, ad,
                             (k == 1) ? base : base1);
        end
      end
      tick();
    end
    drive(u, 1'b0, 2'b00);
    if (!rsvd) last_vec[u] = expv;
  endtask

  task automatic test_reset();
    logic en, bz, dn, er;
    logic [15:0] ad, vc;
    reset = 1'b1;
    repeat (3) tick();
    for (int u = 0; u < 3; u++) begin
      sample(u, en, ad, bz, dn, er, vc);
      checks++;
      if ({en, bz, dn, er} !== 4'b0 || ad !== 16'h0 || vc !== 16'h0) begin
        errors++; $display("FAIL reset_state u%0d got en%b bz%b dn%b er%b ad%h vc%h exp zeros",
                           u, en, bz, dn, er, ad, vc);
      end
      last_vec[u] = 16'h0;
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset_vector();
    int nd; bit sf;
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
    run_fetch(0, 2'b00, 16'h0, nd, sf);
    checks++;
    if (vec_a !== 16'h8000) begin errors++; $display("FAIL reset_vec got %h exp 8000", vec_a); end
  endtask

  task automatic test_zero_latency();
    int nd; bit sf;
    mem[16'hFFFA] = 8'h34; mem[16'hFFFB] = 8'h12;
    run_fetch(1, 2'b01, 16'h0, nd, sf);
    checks++;
    if (vec_b !== 16'h1234) begin errors++; $display("FAIL nmi_l0 got %h exp 1234", vec_b); end
  endtask

  task automatic test_busy_ignore();
    int nd; bit sf;
    mem[16'hFFFE] = 8'h11; mem[16'hFFFF] = 8'h22;
    run_fetch(0, 2'b10, 16'h0024, nd, sf);  // pokes at n+2 and at DONE (n+5)
    checks += 2;
    if (nd != 1) begin errors++; $display("FAIL busy_ignore_done got %0d exp 1", nd); end
    if (sf) begin errors++; $display("FAIL busy_ignore_addr got FFFC exp never"); end
  endtask

  task automatic test_reset_mid();
    int nd; bit sf;
    logic en, bz, dn, er;
    logic [15:0] ad, vc;
    mem[16'hFFFC] = 8'h5A; mem[16'hFFFD] = 8'hC3;
    drive(0, 1'b1, 2'b00);
    tick();
    drive(0, 1'b0, 2'b00);
    tick(); tick();          // now in n+3
    reset = 1'b1;
    tick();                  // n+4
    reset = 1'b0;
    sample(0, en, ad, bz, dn, er, vc);
    checks++;
    if ({en, bz, dn} !== 3'b0 || vc !== 16'h0) begin
      errors++; $display("FAIL reset_mid got en%b bz%b dn%b vc%h exp 0", en, bz, dn, vc);
    end
    for (int u = 0; u < 3; u++) last_vec[u] = 16'h0;
    repeat (3) begin
      tick();
      checks++;
      if (done_a !== 1'b0) begin errors++; $display("FAIL reset_mid_done got 1 exp 0"); end
    end
    run_fetch(0, 2'b00, 16'h0, nd, sf);
  endtask

  task automatic test_wrap();
    int nd; bit sf;
    mem[16'hFFFF] = 8'hCD; mem[16'h0000] = 8'hAB;
    run_fetch(2, 2'b00, 16'h0, nd, sf);
    checks++;
    if (vec_c !== 16'hABCD) begin errors++; $display("FAIL wrap got %h exp ABCD", vec_c); end
  endtask

  task automatic test_reserved();
    int nd; bit sf;
    logic [15:0] prev;
    mem[16'hFFFE] = 8'hEF; mem[16'hFFFF] = 8'hBE;
    prev = vec_a;
    run_fetch(0, 2'b11, 16'h0, nd, sf);
    checks++;
    if (vec_a !== (RSVD ? prev : 16'hBEEF)) begin
      errors++; $display("FAIL reserved got %h exp %h", vec_a, RSVD ? prev : 16'hBEEF);
    end
  endtask

  task automatic test_random();
    int nd; bit sf;
    int u;
    logic [1:0] s;
    logic [15:0] b;
    for (int i = 0; i < 24; i++) begin
      u = $urandom_range(0, 2);
      s = 2'($urandom_range(0, 3));
      b = vaddr(u, s);
      mem[b] = 8'($urandom);
      mem[16'(b + 16'd1)] = 8'($urandom);
      run_fetch(u, s, 16'($urandom), nd, sf);
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'(a ^ (a >> 8));
    test_reset();
    test_reset_vector();
    test_zero_latency();
    test_busy_ignore();
    test_reset_mid();
    test_wrap();
    test_reserved();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
